// File: rtl/audio_pkg.sv
// Shared types and widths for the audio voice path.
// Voice 1 is built only when AUDIO_SEQ_VOICE1_EN is defined.
package audio_pkg;

  localparam int PHASE_W  = 16;
  localparam int SAMPLE_W = 16;
  localparam int ROM_DW   = 8;
  localparam int VOL_W    = 4;
  localparam int MIX_W    = 13;

  typedef enum logic [2:0] {
    IDLE,
    FETCH0,
    WAIT0,
    FETCH1,
    WAIT1,
    MIX
  } seq_state_t;

  // one voice's contribution: byte times volume, zero-extended
  function automatic logic [MIX_W-1:0] scale(
    input logic [ROM_DW-1:0] d,
    input logic [VOL_W-1:0]  v
  );
    return MIX_W'(d) * MIX_W'(v);
  endfunction

endpackage

// File: rtl/audio_tick_gen.sv
// Sample-rate divider: one-cycle tick every SAMPLE_DIV clocks.
// Counter is parked at zero while enable is low.
module audio_tick_gen #(
  parameter int SAMPLE_DIV = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] cnt;

  // free-running divider, wraps after LAST
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (!enable) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/audio_voice_sequencer.sv
// Wavetable voice sequencer: shares one ROM port across voices per tick.
// AUDIO_SEQ_VOICE1_EN adds the second voice; otherwise single voice.
module audio_voice_sequencer
  import audio_pkg::*;
#(
  parameter int SAMPLE_DIV = 1024,
  parameter int ROM_AW     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PHASE_W-1:0]  phase_inc0,
  input  logic [PHASE_W-1:0]  phase_inc1,
  input  logic [VOL_W-1:0]    vol0,
  input  logic [VOL_W-1:0]    vol1,
  output logic                rom_req,
  output logic [ROM_AW-1:0]   rom_addr,
  input  logic [ROM_DW-1:0]   rom_data,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  output logic                busy
);

  seq_state_t         state;
  logic               tick;
  logic [PHASE_W-1:0] acc0;
  logic [ROM_DW-1:0]  d0;
  logic [MIX_W-1:0]   m;

`ifdef AUDIO_SEQ_VOICE1_EN
  logic [PHASE_W-1:0] acc1;
  logic [ROM_DW-1:0]  d1;
`else
  logic               unused_voice1;
  assign unused_voice1 = ^{phase_inc1, vol1};
`endif

  audio_tick_gen #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .tick  (tick)
  );

  // scaled voice mix, consumed only in MIX
  always_comb begin
    m = scale(d0, vol0);
`ifdef AUDIO_SEQ_VOICE1_EN
    m = m + scale(d1, vol1);
`endif
  end

  // fetch/mix sequencer with registered ROM strobe and sample outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rom_req      <= 1'b0;
      rom_addr     <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      acc0         <= '0;
      d0           <= '0;
`ifdef AUDIO_SEQ_VOICE1_EN
      acc1         <= '0;
      d1           <= '0;
`endif
    end else begin
      rom_req      <= 1'b0;
      sample_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tick) begin
            state    <= FETCH0;
            rom_req  <= 1'b1;
            rom_addr <= acc0[PHASE_W-1 -: ROM_AW];
          end
        end
        FETCH0: state <= WAIT0;
        WAIT0: begin
          d0 <= rom_data;
`ifdef AUDIO_SEQ_VOICE1_EN
          state    <= FETCH1;
          rom_req  <= 1'b1;
          rom_addr <= acc1[PHASE_W-1 -: ROM_AW];
`else
          state    <= MIX;
`endif
        end
`ifdef AUDIO_SEQ_VOICE1_EN
        FETCH1: state <= WAIT1;
        WAIT1: begin
          d1    <= rom_data;
          state <= MIX;
        end
`endif
        MIX: begin
          sample       <= {m, 3'b000};
          sample_valid <= 1'b1;
          acc0         <= acc0 + phase_inc0;
`ifdef AUDIO_SEQ_VOICE1_EN
          acc1         <= acc1 + phase_inc1;
`endif
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_audio_voice_sequencer.sv
// Directed bench for audio_voice_sequencer with SAMPLE_DIV=16.
// ROM model returns data = addr one cycle after rom_req.
module tb_audio_voice_sequencer;

  localparam int DIV = 16;
`ifdef AUDIO_SEQ_VOICE1_EN
  localparam int LAT    = 6;
  localparam int NREQ   = 2;
  localparam int VOICES = 2;
`else
  localparam int LAT    = 4;
  localparam int NREQ   = 1;
  localparam int VOICES = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] phase_inc0 = '0;
  logic [15:0] phase_inc1 = '0;
  logic [3:0]  vol0 = '0;
  logic [3:0]  vol1 = '0;
  logic        rom_req;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_data = '0;
  logic [15:0] sample;
  logic        sample_valid;
  logic        busy;
  logic        force_ff = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nvalid = 0;
  int nreq = 0;

  audio_voice_sequencer #(
    .SAMPLE_DIV(DIV),
    .ROM_AW    (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .phase_inc0  (phase_inc0),
    .phase_inc1  (phase_inc1),
    .vol0        (vol0),
    .vol1        (vol1),
    .rom_req     (rom_req),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .sample      (sample),
    .sample_valid(sample_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_req) rom_data <= force_ff ? 8'hFF : rom_addr;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sample_valid) nvalid <= nvalid + 1;
    if (rom_req) nreq <= nreq + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_to(input string tag, input int n);
    checks++;
    assert (n < 200) else begin
      errors++;
      $error("FAIL %s observed=%0d cycles expected<200", tag, n);
    end
  endtask

  task automatic wait_req(output int t);
    int n;
    n = 0;
    while (rom_req !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk_to("req_timeout", n);
    t = cyc;
  endtask

  task automatic wait_valid(output int t);
    int n;
    n = 0;
    while (sample_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk_to("valid_timeout", n);
    t = cyc;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int tq, tv, tvp, v0, r0;
    tvp = 0;

    // reset state
    @(negedge clk);
    do_reset();
    chk("rst_req", rom_req, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_sample", sample, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_busy", busy, 0);
    repeat (20) @(negedge clk);
    chk("idle_nreq", nreq, 0);
    chk("idle_busy", busy, 0);

    // single voice
    vol0 = 4'd15; vol1 = 4'd0;
    phase_inc0 = 16'h0100; phase_inc1 = 16'h0000;
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_req(tq);
      chk("sv_addr", rom_addr, k);
      chk("sv_busy", busy, 1);
      wait_valid(tv);
      chk("sv_sample", sample, 120 * k);
      chk("sv_lat", tv - tq, LAT - 1);
      if (k > 0) chk("sv_period", tv - tvp, DIV);
      tvp = tv;
      @(negedge clk);
      chk("sv_pulse", sample_valid, 0);
      chk("sv_hold", sample, 120 * k);
    end

    // two-voice mix
    enable = 1'b0;
    do_reset();
    vol0 = 4'd15; vol1 = 4'd15;
    phase_inc0 = 16'h0100; phase_inc1 = 16'h0100;
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_req(tq);
      r0 = nreq;
      chk("mix_addr0", rom_addr, k);
      wait_valid(tv);
      chk("mix_sample", sample, 120 * VOICES * k);
      chk("mix_nreq", nreq - r0, NREQ);
      chk("mix_addr_hold", rom_addr, k);
      @(negedge clk);
    end

    // phase wrap
    enable = 1'b0;
    do_reset();
    vol0 = 4'd15; vol1 = 4'd0;
    phase_inc0 = 16'h8000; phase_inc1 = 16'h0000;
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_req(tq);
      chk("wrap_addr", rom_addr, (k % 2) * 128);
      wait_valid(tv);
      chk("wrap_sample", sample, (k % 2) * 15360);
      @(negedge clk);
    end

    // full scale
    force_ff = 1'b1;
    vol1 = 4'd15;
    wait_req(tq);
    wait_valid(tv);
    chk("full_scale", sample, 255 * 15 * 8 * VOICES);
    @(negedge clk);
    force_ff = 1'b0;

    // enable drop during WAIT0
    enable = 1'b0;
    do_reset();
    vol0 = 4'd15; vol1 = 4'd0;
    phase_inc0 = 16'h0100; phase_inc1 = 16'h0100;
    enable = 1'b1;
    wait_req(tq);
    wait_valid(tv);
    @(negedge clk);
    wait_req(tq);
    @(negedge clk);
    enable = 1'b0;
    v0 = nvalid;
    wait_valid(tv);
    chk("drop_sample", sample, 120);
    r0 = nreq;
    repeat (40) @(negedge clk);
    chk("drop_nvalid", nvalid - v0, 1);
    chk("drop_nreq", nreq, r0);
    chk("drop_busy", busy, 0);

    // reset mid-sequence
    vol1 = 4'd15;
    enable = 1'b1;
    wait_req(tq);
    chk("rmid_addr_pre", rom_addr, 2);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    v0 = nvalid;
    @(negedge clk);
    reset = 1'b0;
    chk("rmid_busy", busy, 0);
    chk("rmid_req", rom_req, 0);
    chk("rmid_valid", sample_valid, 0);
    chk("rmid_sample", sample, 0);
    repeat (4) @(negedge clk);
    chk("rmid_nvalid", nvalid, v0);
    wait_req(tq);
    chk("rmid_acc0", rom_addr, 0);
    wait_valid(tv);
    chk("rmid_post_sample", sample, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_voice_sequencer.md
# audio_voice_sequencer

Two-voice wavetable playback controller for the audio path. It owns the shared 8-bit wavetable ROM port and time-multiplexes it between two phase-accumulator voices once per sample tick. It scales each fetched byte by a per-voice volume, mixes the two voices, and delivers a 16-bit unsigned sample to the PDM modulator. It sits between the wavetable ROM and `pdm`, in place of the free-running counter addressing.

## Interface
Parameters:
- `SAMPLE_DIV`, 1024: clk cycles per sample tick. Must be ≥ 8.
- `ROM_AW`, 8: wavetable address width. Address is taken from `acc[15:16-ROM_AW]`.

Ports:
- `clk`  in  1  system clock (pixel clock domain).
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  level. Low stops new sample ticks.
- `phase_inc0`  in  16  voice 0 phase increment per sample.
- `phase_inc1`  in  16  voice 1 phase increment per sample.
- `vol0`  in  4  voice 0 volume, 0 = silent, 15 = full.
- `vol1`  in  4  voice 1 volume.
- `rom_req`  out  1  ROM read strobe.
- `rom_addr`  out  ROM_AW  ROM read address. Valid while `rom_req` is high.
- `rom_data`  in  8  ROM read data. Valid exactly 1 cycle after `rom_req`.
- `sample`  out  16  mixed sample, unsigned. Held between updates.
- `sample_valid`  out  1  one-cycle pulse when `sample` updates.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Tick counter counts 0..SAMPLE_DIV-1 while `enable` is high and wraps to 0.
  - The tick fires in the cycle the counter equals SAMPLE_DIV-1.
  - While `enable` is low, the counter is held at 0.
- FSM states: IDLE → FETCH0 → WAIT0 → FETCH1 → WAIT1 → MIX → IDLE.
  - IDLE → FETCH0 on tick. All other transitions are unconditional, one per cycle.
- FETCH0: `rom_req`=1, `rom_addr`=acc0[15:8].
- WAIT0: capture `rom_data` into d0.
- FETCH1 and WAIT1: same as FETCH0/WAIT0, using acc1 and d1.
- `rom_req` is 0 in every other state, and `rom_addr` holds its last value.
- MIX:
  - m = d0*vol0 + d1*vol1, 13 bits, no overflow (max 7650).
  - `sample` ← {m, 3'b000}. Maximum value 0xEF10.
  - acc0 ← acc0 + phase_inc0 and acc1 ← acc1 + phase_inc1, modulo 2^16.
- The address used in a sequence is always the accumulator value from before that sequence's MIX update.
- `phase_inc*` and `vol*` are sampled in MIX only. Mid-sequence changes take effect on that MIX.
- Deasserting `enable` mid-sequence does not abort. The sequence completes and `sample_valid` still pulses.

## Timing
- Reset values: FSM=IDLE, counter=0, acc0=acc1=0, d0=d1=0. Outputs `rom_req`=0, `rom_addr`=0, `sample`=0, `sample_valid`=0, `busy`=0.
- Tick at cycle T gives:
  - FETCH0 at T+1, WAIT0 at T+2, FETCH1 at T+3, WAIT1 at T+4, MIX at T+5.
  - `sample_valid`=1 during T+6, with new `sample` visible from T+6.
- `busy` is high T+1..T+5.
- Because SAMPLE_DIV ≥ 8, a tick never arrives outside IDLE. No tick queueing is needed.
- Reset asserted mid-sequence returns to IDLE the next cycle. No partial `sample_valid` is produced.
- Simultaneous tick and reset: reset wins.

## Configuration
- `AUDIO_SEQ_VOICE1_EN` defined: two voices, as described above.
- Undefined:
  - FETCH1 and WAIT1 are removed; WAIT0 → MIX.
  - acc1 and d1 are absent, and m = d0*vol0.
  - `phase_inc1` and `vol1` are ignored.
  - Tick-to-valid latency becomes 4 cycles (MIX at T+3, valid at T+4).

## Structure
- Shared package `audio_pkg`:
  - FSM state enum `seq_state_t`.
  - `PHASE_W`=16, `SAMPLE_W`=16, `ROM_DW`=8, `VOL_W`=4.
- Sub-module `audio_tick_gen`: the SAMPLE_DIV divider with `enable` and a one-cycle `tick` output.

## Test plan
All scenarios use SAMPLE_DIV=16 and a ROM model returning data = addr with 1-cycle latency.

- **Reset:** hold reset 3 cycles → all outputs 0, `busy`=0, no `rom_req` for 20 cycles with `enable`=0.
- **Single voice:** vol0=15, vol1=0, inc0=0x0100 → successive `sample` values 0, 120, 240, 360. `sample_valid` pulses every 16 cycles, 6 cycles after tick.
- **Mix:** vol0=vol1=15, inc0=inc1=0x0100 → samples 0, 240, 480. `rom_addr` sequence n, n per tick.
- **Wrap and full scale:**
  - inc0=0x8000 → `rom_addr` alternates 0x00 and 0x80.
  - ROM forced to 0xFF with both vol=15 → `sample`=0xEF10.
- **Enable drop mid-sequence:** deassert `enable` during WAIT0 → that sample still completes with one `sample_valid`; no further `rom_req`.
- **Reset mid-sequence:** assert reset in FETCH1 → IDLE next cycle, no `sample_valid`, acc0=acc1=0.
